// File: rtl/audio_nios_sd_clkgen_if.sv
// Avalon-MM slave bus of the SD clock generator: word address, write strobe, combinational read.
interface audio_nios_sd_clkgen_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/audio_nios_sd_clkgen.sv
// Parallel output port with a burst clock generator on CLK_BIT: COUNT pulses of
// DIV+1 cycles active / DIV+1 cycles rest, then DONE (optionally irq).
module audio_nios_sd_clkgen #(
  parameter int DATA_WIDTH = 1,
  parameter int DIV_WIDTH  = 16,
  parameter int CNT_WIDTH  = 16,
  parameter int CLK_BIT    = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  audio_nios_sd_clkgen_if.slave  bus,
  output logic [DATA_WIDTH-1:0]  out_port,
  output logic                   irq
);
  typedef enum logic [1:0] {IDLE, ACTIVE, REST} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, out_q, out_d;
  logic [DIV_WIDTH-1:0]  div_q, phase_q, phase_d;
  logic [CNT_WIDTH-1:0]  rem_q, rem_d;
  logic                  mode_q, cpol_q, ie_q, done_q;
  logic                  done_set, busy, gen_bit;
  logic                  wr, wr_data, wr_div, wr_cnt, wr_ctrl, start, abort;
  logic                  unused_wd;

  assign wr      = bus.chipselect & ~bus.write_n;
  assign wr_data = wr & (bus.address == 2'd0);
  assign wr_div  = wr & (bus.address == 2'd1);
  assign wr_cnt  = wr & (bus.address == 2'd2);
  assign wr_ctrl = wr & (bus.address == 2'd3);
  assign start   = wr_cnt & mode_q & ~busy & (bus.writedata[CNT_WIDTH-1:0] != '0);
  assign abort   = wr_ctrl & ~bus.writedata[0] & busy;
  assign unused_wd = ^bus.writedata;

  // Generator state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      phase_q <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      rem_q   <= rem_d;
    end
  end

  // Next state: phase counter runs DIV..0, so every phase lasts DIV+1 cycles
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    rem_d    = rem_q;
    done_set = 1'b0;
    if (abort) begin
      state_d = IDLE;
      phase_d = '0;
      rem_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_d = ACTIVE;
          phase_d = div_q;
          rem_d   = bus.writedata[CNT_WIDTH-1:0];
        end
        ACTIVE: if (phase_q == '0) begin
          state_d = REST;
          phase_d = div_q;
          if (rem_q != '0) rem_d = rem_q - CNT_WIDTH'(1);
        end else phase_d = phase_q - DIV_WIDTH'(1);
        REST: if (phase_q == '0) begin
          if (rem_q != '0) begin
            state_d = ACTIVE;
            phase_d = div_q;
          end else begin
            state_d  = IDLE;
            done_set = 1'b1;
          end
        end else phase_d = phase_q - DIV_WIDTH'(1);
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs: CPOL is read live so a polarity change lands on the current phase
  always_comb begin
    busy    = (state_q != IDLE);
    gen_bit = (state_q == ACTIVE) ? ~cpol_q : cpol_q;
    out_d   = data_q;
    if (mode_q) out_d[CLK_BIT] = gen_bit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      div_q  <= '0;
      mode_q <= 1'b0;
      cpol_q <= 1'b0;
      ie_q   <= 1'b0;
      done_q <= 1'b0;
      out_q  <= '0;
    end else begin
      if (wr_data) data_q <= bus.writedata[DATA_WIDTH-1:0];
      if (wr_div && !busy) div_q <= bus.writedata[DIV_WIDTH-1:0];
      if (wr_ctrl) begin
        mode_q <= bus.writedata[0];
        cpol_q <= bus.writedata[1];
        ie_q   <= bus.writedata[2];
      end
      if (done_set) done_q <= 1'b1;
      else if (wr_ctrl && bus.writedata[3]) done_q <= 1'b0;
      out_q <= out_d;
    end
  end

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      2'd0:    bus.readdata[DATA_WIDTH-1:0] = data_q;
      2'd1:    bus.readdata[DIV_WIDTH-1:0]  = div_q;
      2'd2:    bus.readdata[CNT_WIDTH-1:0]  = rem_q;
      default: bus.readdata[4:0] = {busy, done_q, ie_q, cpol_q, mode_q};
    endcase
  end

  assign out_port = out_q;
  assign irq      = done_q & ie_q;
endmodule

// File: tb/tb_audio_nios_sd_clkgen.sv
// Bench for audio_nios_sd_clkgen: register access, bursts, irq, ignored writes, abort, reset.
module tb_audio_nios_sd_clkgen;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] out_port;
  logic       irq;
  logic [31:0] rdv;
  int n_cmp = 0, n_err = 0;

  typedef struct { string tag; logic [31:0] exp; } exp_t;
  exp_t sb[$];

  audio_nios_sd_clkgen_if bus();

  audio_nios_sd_clkgen #(.DATA_WIDTH(4), .DIV_WIDTH(16), .CNT_WIDTH(16), .CLK_BIT(0)) dut (
    .clk(clk), .reset(rst), .bus(bus), .out_port(out_port), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; the write lands on the next edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
    @(posedge clk); #1;
    bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.address = 2'd3;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.address = a; #1;
    d = bus.readdata;
    bus.address = 2'd3;
  endtask

  task automatic align;
    @(posedge clk); #1;
  endtask

  // Called right after the COUNT write edge E; sample k follows edge E+k (CPOL=0).
  task automatic burst(input int div, input int cnt, input logic [3:0] data);
    int per = div + 1;
    int n = 2 * per * cnt;
    exp_t e;
    for (int k = 0; k <= n + 1; k++) begin
      logic hi;
      hi = (k >= 1) && (k <= n) && (((k - 1) / per) % 2 == 0);
      sb.push_back('{$sformatf("out k%0d", k), {28'd0, data[3:1], hi}});
      sb.push_back('{$sformatf("busy k%0d", k), {31'd0, (k < n)}});
    end
    for (int k = 0; k <= n + 1; k++) begin
      @(negedge clk);
      e = sb.pop_front();
      chk(e.tag, {28'd0, out_port}, e.exp);
      e = sb.pop_front();
      if (bus.address == 2'd3) chk(e.tag, {31'd0, bus.readdata[4]}, e.exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.address = 2'd3; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst out", {28'd0, out_port}, 32'h0);
    chk("rst irq", {31'd0, irq}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], rdv);
      chk($sformatf("rst reg%0d", a), rdv, 32'h0);
    end

    // Manual mode
    align;
    wr(2'd0, 32'hFFFF_FFFA);
    @(negedge clk);
    chk("man out lag", {28'd0, out_port}, 32'h0);
    rd(2'd0, rdv); chk("man rd data", rdv, 32'h0000_000A);
    @(negedge clk);
    chk("man out", {28'd0, out_port}, 32'hA);

    // Auto idle with CPOL=1 drives CLK_BIT high
    align;
    wr(2'd3, 32'h3);
    @(negedge clk); @(negedge clk);
    chk("cpol1 idle", {28'd0, out_port}, 32'hB);

    // Burst DIV=2 COUNT=3
    align;
    wr(2'd3, 32'h1);
    wr(2'd1, 32'h2);
    wr(2'd2, 32'h3);
    burst(2, 3, 4'hA);
    rd(2'd3, rdv); chk("burst ctrl", rdv, 32'h9);
    rd(2'd2, rdv); chk("burst cnt", rdv, 32'h0);
    chk("burst irq off", {31'd0, irq}, 32'h0);

    // Interrupt enable / clear
    align;
    wr(2'd3, 32'h5);
    @(negedge clk);
    chk("irq set", {31'd0, irq}, 32'h1);
    align;
    wr(2'd3, 32'hD);
    @(negedge clk);
    chk("irq clr", {31'd0, irq}, 32'h0);
    rd(2'd3, rdv); chk("done clr", rdv, 32'h5);

    // Clear coinciding with DONE set: DIV=0 COUNT=1 ends two edges after start
    align;
    wr(2'd1, 32'h0);
    wr(2'd2, 32'h1);
    align;
    wr(2'd3, 32'hD);
    @(negedge clk);
    rd(2'd3, rdv); chk("set beats clr", rdv, 32'hD);
    chk("set beats clr irq", {31'd0, irq}, 32'h1);

    // Ignored COUNT/DIV writes mid-burst
    align;
    wr(2'd3, 32'hD);
    wr(2'd1, 32'h2);
    wr(2'd2, 32'h3);
    fork
      burst(2, 3, 4'hA);
      begin
        repeat (4) @(posedge clk);
        #1;
        wr(2'd2, 32'h5);
        wr(2'd1, 32'h9);
      end
    join
    rd(2'd1, rdv); chk("ign div", rdv, 32'h2);
    rd(2'd2, rdv); chk("ign cnt", rdv, 32'h0);
    rd(2'd3, rdv); chk("ign ctrl", rdv, 32'hD);

    // Abort after one pulse of COUNT=4
    align;
    wr(2'd3, 32'h9);
    wr(2'd2, 32'h4);
    repeat (6) @(posedge clk);
    #1;
    wr(2'd3, 32'h0);
    @(negedge clk);
    rd(2'd3, rdv); chk("abort ctrl", rdv, 32'h0);
    rd(2'd2, rdv); chk("abort cnt", rdv, 32'h0);
    @(negedge clk);
    chk("abort out", {28'd0, out_port}, 32'hA);

    // COUNT in manual mode and COUNT=0 in auto mode are ignored
    align;
    wr(2'd2, 32'h3);
    @(negedge clk);
    rd(2'd3, rdv); chk("man cnt ign", rdv, 32'h0);
    align;
    wr(2'd3, 32'h1);
    wr(2'd2, 32'h0);
    @(negedge clk);
    rd(2'd3, rdv); chk("zero cnt ign", rdv, 32'h1);

    // Reset during ACTIVE
    align;
    wr(2'd1, 32'h3);
    wr(2'd2, 32'h4);
    @(negedge clk); @(negedge clk);
    chk("pre-rst active", {28'd0, out_port}, 32'hB);
    #1 rst = 1'b1;
    #1;
    chk("async rst out", {28'd0, out_port}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], rdv);
      chk($sformatf("post-rst reg%0d", a), rdv, 32'h0);
    end
    chk("post-rst out", {28'd0, out_port}, 32'h0);
    chk("post-rst irq", {31'd0, irq}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
